// File: rtl/emu_ram_scan_ctrl.sv
// Emulation RAM with a 1R1W user port and a beat-serial checkpoint scan port over a BASE/COUNT window.
// Define EMU_RAM_SCAN_CHK_EN to append an XOR checksum beat to every dump and restore.
module emu_ram_scan_ctrl #(
   parameter int WIDTH      = 80,
   parameter int DEPTH      = 64,
   parameter int SCAN_WIDTH = 64,
   parameter int BASE       = 32,
   parameter int COUNT      = 32,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  halt,
   input  logic                  scan,
   input  logic                  dir,
   input  logic [SCAN_WIDTH-1:0] sdi,
   output logic [SCAN_WIDTH-1:0] sdo,
   input  logic [AW-1:0]         raddr,
   output logic [WIDTH-1:0]      rdata,
   input  logic                  wen,
   input  logic [AW-1:0]         waddr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  scan_busy,
   output logic                  scan_done,
   output logic                  chk_err
);

   localparam int B   = (WIDTH + SCAN_WIDTH - 1) / SCAN_WIDTH;
   localparam int PW  = B * SCAN_WIDTH;
   localparam int BW  = (B > 1) ? $clog2(B) : 1;
   localparam int WCW = $clog2(COUNT + 1);

   generate
      if (BASE + COUNT > DEPTH) begin : g_bad_window
         $error("emu_ram_scan_ctrl: BASE+COUNT exceeds DEPTH");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, PREFILL, SHIFT_OUT, SHIFT_IN, DONE} state_t;

   state_t                  state, state_next;
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [BW-1:0]           beat_cnt;
   logic [WCW-1:0]          word_cnt;
   logic [WIDTH-1:0]        word_buf;
   logic [WIDTH-1:0]        asm_buf;
   logic [WIDTH-1:0]        wr_word;
   logic [PW-1:0]           padded;
   logic [SCAN_WIDTH-1:0]   cur_beat;
   logic [SCAN_WIDTH-1:0]   xor_acc;
   logic [SCAN_WIDTH-1:0]   sdo_next;
   logic [AW-1:0]           scan_addr, fetch_addr;
   logic                    go, last_beat, last_word, in_window;
   logic                    emit, capture, fetch, chk_beat;

   assign go         = scan & halt;
   assign last_beat  = (beat_cnt == BW'(B - 1));
   assign last_word  = (word_cnt == WCW'(COUNT - 1));
   assign in_window  = (word_cnt != WCW'(COUNT));
   assign scan_addr  = AW'(BASE + int'(word_cnt));
   assign fetch_addr = (state == PREFILL) ? AW'(BASE) : AW'(BASE + int'(word_cnt) + 1);
   assign scan_busy  = (state != IDLE) && (state != DONE);
   assign scan_done  = (state == DONE);

   // Dump words are zero-padded to a whole number of beats before slicing.
   always_comb begin
      padded = '0;
      padded[WIDTH-1:0] = word_buf;
   end
   assign cur_beat = padded[int'(beat_cnt)*SCAN_WIDTH +: SCAN_WIDTH];

   // Restore assembly: the incoming beat overlays its slot, padding bits of the top beat fall away.
   always_comb begin
      wr_word = asm_buf;
      for (int i = 0; i < WIDTH; i++) begin
         if (i / SCAN_WIDTH == int'(beat_cnt)) wr_word[i] = sdi[i % SCAN_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      emit       = 1'b0;
      capture    = 1'b0;
      fetch      = 1'b0;
      chk_beat   = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               state_next = dir ? SHIFT_IN : PREFILL;
               capture    = dir;
            end
         end
         PREFILL: begin
            if (!go) state_next = IDLE;
            else begin
               state_next = SHIFT_OUT;
               fetch      = 1'b1;
            end
         end
         SHIFT_OUT: begin
            if (!go) state_next = IDLE;
            else if (in_window) begin
               emit  = 1'b1;
               fetch = last_beat && !last_word;
            end else begin
`ifdef EMU_RAM_SCAN_CHK_EN
               if (beat_cnt == '0) chk_beat = 1'b1;
               else                state_next = DONE;
`else
               state_next = DONE;
`endif
            end
         end
         SHIFT_IN: begin
            if (!go) state_next = IDLE;
            else if (in_window) begin
               capture = 1'b1;
`ifndef EMU_RAM_SCAN_CHK_EN
               if (last_beat && last_word) state_next = DONE;
`endif
            end else begin
               chk_beat   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (!go) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign sdo_next = emit ? cur_beat :
                     (chk_beat && state == SHIFT_OUT) ? xor_acc : '0;

   // Counters and checksum restart whenever the FSM heads back to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sdo      <= '0;
         beat_cnt <= '0;
         word_cnt <= '0;
         xor_acc  <= '0;
      end else begin
         sdo <= sdo_next;
         if (state_next == IDLE) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            xor_acc  <= '0;
         end else if (emit || capture) begin
            xor_acc <= xor_acc ^ (emit ? cur_beat : sdi);
            if (last_beat) begin
               beat_cnt <= '0;
               word_cnt <= word_cnt + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end else if (chk_beat) begin
            beat_cnt <= BW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (capture && last_beat) mem[scan_addr] <= wr_word;
         else if (!halt && wen)    mem[waddr]     <= wdata;
         if (capture) asm_buf  <= wr_word;
         if (fetch)   word_buf <= mem[fetch_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rdata <= '0;
      else if (!halt) rdata <= mem[raddr];
   end

`ifdef EMU_RAM_SCAN_CHK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                                   chk_err <= 1'b0;
      else if (state == IDLE && go)                 chk_err <= 1'b0;
      else if (chk_beat && state == SHIFT_IN && sdi != xor_acc) chk_err <= 1'b1;
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule
